// File: rtl/fft_bitrev_loader.sv
// FFT input loader: writes time-ordered samples into a ping-pong buffer
// at bit-reversed addresses, then commits the filled bank downstream.
module fft_bitrev_loader #(
  parameter int DataWidth    = 32,
  parameter int LogN         = 5,
  parameter int AddressWidth = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic                    buf_ce,
  output logic                    buf_write,
  input  logic                    buf_full_n,
  output logic                    buf_ce0,
  output logic                    buf_we0,
  output logic [AddressWidth-1:0] buf_address0,
  output logic [DataWidth-1:0]    buf_d0,
  output logic [15:0]             frame_count,
  output logic                    err_last
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LogN-1:0] idx;
  logic [LogN-1:0] idx_rev;
  logic            accept;
  logic            idx_last;
  logic            commit_done;

  assign accept      = in_valid & in_ready;
  assign idx_last    = &idx;
  assign commit_done = (state == COMMIT) & buf_full_n;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (buf_full_n) state_nxt = LOAD;
      LOAD:    if (accept && idx_last) state_nxt = COMMIT;
      COMMIT:  if (buf_full_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    buf_ce    = (state == COMMIT);
    buf_write = (state == COMMIT);
  end

  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < LogN; i++)
      idx_rev[i] = idx[LogN-1-i];
  end

  assign buf_ce0      = accept;
  assign buf_we0      = accept;
  assign buf_address0 = AddressWidth'(idx_rev);
  assign buf_d0       = in_data;

  // idx wraps naturally to 0 after N-1 since N = 2^LogN
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      frame_count <= '0;
      err_last    <= 1'b0;
    end else begin
      if (accept) begin
        idx <= idx + 1'b1;
        if (in_last != idx_last) err_last <= 1'b1;
      end
      if (commit_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader with N=8: bit-reversed writes,
// backpressure, gapped input, framing errors and mid-frame reset.
module tb_fft_bitrev_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        buf_ce;
  logic        buf_write;
  logic        buf_full_n;
  logic        buf_ce0;
  logic        buf_we0;
  logic [9:0]  buf_address0;
  logic [31:0] buf_d0;
  logic [15:0] frame_count;
  logic        err_last;

  int errors = 0;
  int checks = 0;
  int writes;
  int strobes;
  logic [9:0] rev [8];

  fft_bitrev_loader #(
    .DataWidth(32),
    .LogN(3),
    .AddressWidth(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .buf_ce(buf_ce),
    .buf_write(buf_write),
    .buf_full_n(buf_full_n),
    .buf_ce0(buf_ce0),
    .buf_we0(buf_we0),
    .buf_address0(buf_address0),
    .buf_d0(buf_d0),
    .frame_count(frame_count),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rev[0] = 10'd0; rev[1] = 10'd4; rev[2] = 10'd2; rev[3] = 10'd6;
    rev[4] = 10'd1; rev[5] = 10'd5; rev[6] = 10'd3; rev[7] = 10'd7;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    buf_full_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_ce", 32'(buf_ce), 0);
    chk("rst_write", 32'(buf_write), 0);
    chk("rst_we0", 32'(buf_we0), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_err", 32'(err_last), 0);

    // Scenario 1: one clean back-to-back frame
    @(negedge clk); reset = 1'b0; #1;
    chk("s1_idle_ready", 32'(in_ready), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(i); in_last = (i == 7);
      #1;
      chk("s1_ready", 32'(in_ready), 1);
      chk("s1_we0", 32'(buf_we0), 1);
      chk("s1_ce0", 32'(buf_ce0), 1);
      chk("s1_addr", 32'(buf_address0), 32'(rev[i]));
      chk("s1_d0", buf_d0, 32'(i));
      chk("s1_nowrite", 32'(buf_write), 0);
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
    chk("s1_commit_write", 32'(buf_write), 1);
    chk("s1_commit_ce", 32'(buf_ce), 1);
    chk("s1_commit_ready", 32'(in_ready), 0);
    chk("s1_fc_before", 32'(frame_count), 0);

    // Scenario 2: buffer full while idle
    @(negedge clk); buf_full_n = 1'b0; #1;
    chk("s1_write_pulse", 32'(buf_write), 0);
    chk("s1_fc", 32'(frame_count), 1);
    chk("s1_err", 32'(err_last), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("s2_blocked", 32'(in_ready), 0);
    end
    @(negedge clk); buf_full_n = 1'b1; #1;
    chk("s2_rise_ready", 32'(in_ready), 0);
    @(negedge clk); #1;
    chk("s2_load_ready", 32'(in_ready), 1);

    // Scenario 3: gapped in_valid
    writes = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = (k % 2 == 0);
      in_data  = 32'(100 + k / 2);
      in_last  = (k == 14);
      #1;
      if (buf_we0) writes++;
      if (k % 2 == 0) begin
        chk("s3_addr", 32'(buf_address0), 32'(rev[k/2]));
        chk("s3_d0", buf_d0, 32'(100 + k / 2));
      end else begin
        chk("s3_gap_we0", 32'(buf_we0), 0);
      end
    end
    chk("s3_writes", 32'(writes), 8);
    chk("s3_commit", 32'(buf_write), 1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); #1;
    chk("s3_fc", 32'(frame_count), 2);
    chk("s3_idle", 32'(in_ready), 0);

    // Scenario 4: early in_last, then Scenario 5: held commit
    @(negedge clk); #1;
    chk("s4_ready", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; in_data = 32'(200 + i); in_last = (i == 3);
      #1;
      chk("s4_err", 32'(err_last), 32'(i >= 4));
      chk("s4_addr", 32'(buf_address0), 32'(rev[i]));
    end
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; buf_full_n = (c == 3);
      #1;
      if (buf_write) strobes++;
      chk("s5_fc_hold", 32'(frame_count), 2);
    end
    chk("s5_strobes", 32'(strobes), 4);
    @(negedge clk); #1;
    chk("s5_release", 32'(buf_write), 0);
    chk("s5_fc", 32'(frame_count), 3);
    chk("s4_err_sticky", 32'(err_last), 1);

    // Scenario 6: reset after 5 accepts
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(300 + i); in_last = 1'b0;
      #1;
      chk("s6_addr", 32'(buf_address0), 32'(rev[i]));
    end
    @(negedge clk); in_valid = 1'b0; reset = 1'b1; #1;
    @(negedge clk); #1;
    chk("s6_rst_write", 32'(buf_write), 0);
    chk("s6_rst_ready", 32'(in_ready), 0);
    chk("s6_rst_fc", 32'(frame_count), 0);
    chk("s6_rst_err", 32'(err_last), 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("s6_idle_write", 32'(buf_write), 0);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(400 + i); in_last = (i == 7);
      #1;
      if (buf_write) strobes++;
      chk("s6_addr2", 32'(buf_address0), 32'(rev[i]));
      chk("s6_d0", buf_d0, 32'(400 + i));
    end
    chk("s6_no_commit", 32'(strobes), 0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
    chk("s6_commit", 32'(buf_write), 1);
    @(negedge clk); #1;
    chk("s6_fc", 32'(frame_count), 1);
    chk("s6_err", 32'(err_last), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_bitrev_loader.md
FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 Parameters: DataWidth, default 32, sample width; LogN, default 5, log2 of frame length N; AddressWidth, default 10, buffer address width, LogN <= AddressWidth.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  DataWidth  time-ordered input sample.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  loader accepts a sample this cycle.
REQ-007 in_last  input  1  producer marks the final sample of a frame.
REQ-008 buf_ce  output  1  buffer commit enable.
REQ-009 buf_write  output  1  buffer commit strobe.
REQ-010 buf_full_n  input  1  downstream ping-pong buffer has a free bank.
REQ-011 buf_ce0  output  1  buffer port-0 enable.
REQ-012 buf_we0  output  1  buffer port-0 write enable.
REQ-013 buf_address0  output  AddressWidth  buffer port-0 address.
REQ-014 buf_d0  output  DataWidth  buffer port-0 write data.
REQ-015 frame_count  output  16  frames committed, wraps modulo 2^16.
REQ-016 err_last  output  1  sticky in_last framing error.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and COMMIT; reset state is IDLE.
REQ-018 IDLE: go to LOAD on the next edge when buf_full_n=1, else stay.
REQ-019 in_ready SHALL be 1 exactly when state=LOAD, combinationally from state only.
REQ-020 Accept = in_valid & in_ready; buf_ce0 = buf_we0 = accept, combinational, same cycle.
REQ-021 buf_address0 = bit-reverse of the LogN-bit sample index idx, zero-extended to AddressWidth; buf_d0 = in_data.
REQ-022 idx SHALL reset to 0, increment by 1 per accept, and return to 0 on the accept at idx=N-1.
REQ-023 Accept at idx=N-1 SHALL move LOAD -> COMMIT; in_valid=0 in LOAD holds state and idx.
REQ-024 COMMIT: buf_ce = buf_write = 1; if buf_full_n=1 go to IDLE next edge and increment frame_count, else hold COMMIT with strobes asserted.
REQ-025 buf_ce and buf_write SHALL be 0 outside COMMIT.
REQ-026 Minimum frame period is N+2 cycles: 1 IDLE, N LOAD, 1 COMMIT.
REQ-027 err_last SHALL set on an accept where in_last=1 and idx!=N-1, or in_last=0 and idx=N-1; the frame continues to length N regardless.
REQ-028 err_last SHALL clear only on reset.
REQ-029 frame_count SHALL wrap from 16'hFFFF to 0.
REQ-030 Port-0 writes SHALL occur only in LOAD, so a frame never spans a commit.

Reset
REQ-031 With reset=1 at an edge: state=IDLE, idx=0, frame_count=0, err_last=0.
REQ-032 During and after reset: in_ready, buf_ce, buf_write, buf_ce0 and buf_we0 are 0.
REQ-033 Reset mid-LOAD SHALL discard the partial frame and issue no commit.
REQ-034 Reset SHALL have priority over all other events in the same cycle.

Verification (LogN=3, N=8, AddressWidth=10)
REQ-035 Scenario 1: reset, buf_full_n=1, 8 back-to-back samples 0..7 with in_last on sample 7 -> addresses 0,4,2,6,1,5,3,7 with data 0..7; buf_write pulses 1 cycle; frame_count=1; err_last=0.
REQ-036 Scenario 2: buf_full_n=0 in IDLE for 5 cycles -> in_ready stays 0; LOAD entered one edge after buf_full_n rises.
REQ-037 Scenario 3: in_valid toggled 1,0,1,0 during LOAD -> only valid cycles write; idx advances only on accepts; 8 writes total.
REQ-038 Scenario 4: in_last on sample 3 -> err_last=1 from the next edge; frame still completes at 8 samples and commits; err_last stays 1.
REQ-039 Scenario 5: buf_full_n forced 0 in COMMIT for 3 cycles -> buf_write held 4 cycles; frame_count increments once.
REQ-040 Scenario 6: reset after 5 accepts -> no buf_write; the next frame restarts at address 0; frame_count=0.
